// File: rtl/cordic_iterative_dual_if.sv
// Sample-in / result-out bus of the iterative CORDIC engine.
// The engine is the slave and the sample source/consumer side is the master.
interface cordic_iterative_dual_if #(
    parameter int unsigned W = 8
);
    logic signed [W-1:0] x_i;
    logic signed [W-1:0] y_i;
    logic signed [W-1:0] z_i;
    logic                mode_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic signed [W-1:0] x_o;
    logic signed [W-1:0] y_o;
    logic signed [W-1:0] z_o;
    logic                out_valid_o;
    logic                out_ready_i;

    modport master (
        output x_i, y_i, z_i, mode_i, in_valid_i, out_ready_i,
        input  in_ready_o, x_o, y_o, z_o, out_valid_o
    );

    modport slave (
        input  x_i, y_i, z_i, mode_i, in_valid_i, out_ready_i,
        output in_ready_o, x_o, y_o, z_o, out_valid_o
    );
endinterface

// File: rtl/cordic_iterative_dual.sv
// Iterative rotation/vectoring CORDIC: one shared micro-rotation per clock,
// guard-bit internal datapath with saturating registered outputs.
module cordic_iterative_dual #(
    parameter int unsigned N_FRAC     = 7,
    parameter int unsigned ITERATIONS = 6,
    parameter int unsigned GUARD      = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    cordic_iterative_dual_if.slave  bus
);
    localparam int unsigned W  = N_FRAC + 1;
    localparam int unsigned WI = W + GUARD;
    localparam int unsigned CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    if (N_FRAC < 3 || N_FRAC > 16 || ITERATIONS == 0 || ITERATIONS > 16) begin : g_bad_param
        $error("cordic_iterative_dual: N_FRAC must be 3..16 and ITERATIONS 1..16");
    end

    localparam logic signed [WI-1:0] SAT_HI = WI'((1 << N_FRAC) - 1);
    localparam logic signed [WI-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic signed [WI-1:0]  x_q, y_q, z_q;
    logic                  mode_q;
    logic                  out_valid_q;
    logic signed [W-1:0]   x_o_q, y_o_q, z_o_q;

    logic signed [WI-1:0]  x_d, y_d, z_d;
    logic signed [WI-1:0]  x_sh, y_sh, atan_c;
    logic                  d_pos;

    // atan(2^-i) in units of pi, 16-bit reference scaled down by truncation
    function automatic logic signed [WI-1:0] atan_lut(input logic [3:0] idx);
        logic [16:0] l;
        case (idx)
            4'd0:    l = 17'd16384;
            4'd1:    l = 17'd9672;
            4'd2:    l = 17'd5110;
            4'd3:    l = 17'd2594;
            4'd4:    l = 17'd1302;
            4'd5:    l = 17'd652;
            4'd6:    l = 17'd326;
            4'd7:    l = 17'd163;
            4'd8:    l = 17'd81;
            4'd9:    l = 17'd41;
            4'd10:   l = 17'd20;
            4'd11:   l = 17'd10;
            4'd12:   l = 17'd5;
            4'd13:   l = 17'd3;
            default: l = 17'd1;
        endcase
        return $signed(WI'(l >> (16 - N_FRAC)));
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [WI-1:0] v);
        if (v > SAT_HI) begin
            return W'(SAT_HI);
        end else if (v < SAT_LO) begin
            return W'(SAT_LO);
        end
        return W'(v);
    endfunction

    // One micro-rotation on the working registers
    always_comb begin
        x_sh   = x_q >>> cnt_q;
        y_sh   = y_q >>> cnt_q;
        atan_c = atan_lut(4'(cnt_q));
        d_pos  = mode_q ? y_q[WI-1] : ~z_q[WI-1];
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        if (d_pos) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_c;
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            x_o_q       <= '0;
            y_o_q       <= '0;
            z_o_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid_i) begin
                        x_q     <= WI'($signed(bus.x_i));
                        y_q     <= WI'($signed(bus.y_i));
                        z_q     <= WI'($signed(bus.z_i));
                        mode_q  <= bus.mode_i;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (cnt_q == CW'(ITERATIONS - 1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        x_o_q       <= sat(x_d);
                        y_o_q       <= sat(y_d);
                        z_o_q       <= sat(z_d);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign bus.out_valid_o = out_valid_q;
    assign bus.x_o         = x_o_q;
    assign bus.y_o         = y_o_q;
    assign bus.z_o         = z_o_q;
endmodule

// File: tb/tb_cordic_iterative_dual.sv
// Scoreboard bench: a default-parameter engine and an N_FRAC=11/ITERATIONS=12
// engine, both checked against an integer CORDIC model.
module tb_cordic_iterative_dual;
    localparam int N0 = 7,  IT0 = 6,  G0 = 2;
    localparam int N1 = 11, IT1 = 12, G1 = 2;
    localparam int LUT16 [16] = '{16384, 9672, 5110, 2594, 1302, 652, 326, 163,
                                  81, 41, 20, 10, 5, 3, 1, 1};

    typedef struct { int x; int y; int z; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cordic_iterative_dual_if #(.W(N0 + 1)) bus0 ();
    cordic_iterative_dual_if #(.W(N1 + 1)) bus1 ();

    cordic_iterative_dual #(.N_FRAC(N0), .ITERATIONS(IT0), .GUARD(G0)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0.slave));
    cordic_iterative_dual #(.N_FRAC(N1), .ITERATIONS(IT1), .GUARD(G1)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1.slave));

    function automatic int wrap(int v, int wi);
        int t;
        t = v << (32 - wi);
        return t >>> (32 - wi);
    endfunction

    function automatic int clamp(int v, int n);
        if (v > (1 << n) - 1) return (1 << n) - 1;
        if (v < -(1 << n)) return -(1 << n);
        return v;
    endfunction

    // Plain-integer CORDIC with WI-bit wrap and final saturation to W bits
    function automatic exp_t model(int n, int it, int g, int x0, int y0, int z0, bit m);
        int wi, x, y, z, xn, yn, zn, a;
        bit up;
        exp_t e;
        wi = n + 1 + g;
        x = x0; y = y0; z = z0;
        for (int i = 0; i < it; i++) begin
            a  = LUT16[i] / (1 << (16 - n));
            up = m ? (y < 0) : (z >= 0);
            if (up) begin
                xn = x - (y >>> i); yn = y + (x >>> i); zn = z - a;
            end else begin
                xn = x + (y >>> i); yn = y - (x >>> i); zn = z + a;
            end
            x = wrap(xn, wi); y = wrap(yn, wi); z = wrap(zn, wi);
        end
        e.x = clamp(x, n); e.y = clamp(y, n); e.z = clamp(z, n);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboards: push on accept, pop on each completed output transfer
    always @(negedge clk) begin
        exp_t e;
        if (bus0.in_valid_i && bus0.in_ready_o)
            q0.push_back(model(N0, IT0, G0, int'(bus0.x_i), int'(bus0.y_i), int'(bus0.z_i), bus0.mode_i));
        if (bus0.out_valid_o && bus0.out_ready_i) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_output", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("dut0_x", int'(bus0.x_o), e.x);
                chk("dut0_y", int'(bus0.y_o), e.y);
                chk("dut0_z", int'(bus0.z_o), e.z);
            end
        end
        if (bus1.in_valid_i && bus1.in_ready_o)
            q1.push_back(model(N1, IT1, G1, int'(bus1.x_i), int'(bus1.y_i), int'(bus1.z_i), bus1.mode_i));
        if (bus1.out_valid_o && bus1.out_ready_i) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_output", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("dut1_x", int'(bus1.x_o), e.x);
                chk("dut1_y", int'(bus1.y_o), e.y);
                chk("dut1_z", int'(bus1.z_o), e.z);
            end
        end
    end

    task automatic send0(input int x, input int y, input int z, input bit m);
        bus0.x_i = 8'(x); bus0.y_i = 8'(y); bus0.z_i = 8'(z); bus0.mode_i = m;
        bus0.in_valid_i = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus0.in_ready_o) begin
                @(posedge clk); #1;
                bus0.in_valid_i = 1'b0;
                return;
            end
        end
        chk("dut0_accept_timeout", 0, 1);
        bus0.in_valid_i = 1'b0;
    endtask

    task automatic send1(input int x, input int y, input int z, input bit m);
        bus1.x_i = 12'(x); bus1.y_i = 12'(y); bus1.z_i = 12'(z); bus1.mode_i = m;
        bus1.in_valid_i = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus1.in_ready_o) begin
                @(posedge clk); #1;
                bus1.in_valid_i = 1'b0;
                return;
            end
        end
        chk("dut1_accept_timeout", 0, 1);
        bus1.in_valid_i = 1'b0;
    endtask

    task automatic wait_out0();
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus0.out_valid_o) return;
        end
        chk("dut0_output_timeout", 0, 1);
    endtask

    task automatic wait_out1();
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus1.out_valid_o) return;
        end
        chk("dut1_output_timeout", 0, 1);
    endtask

    task automatic rand_in0();
        bus0.x_i = 8'($urandom); bus0.y_i = 8'($urandom);
        bus0.z_i = 8'($urandom); bus0.mode_i = 1'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   acc [4];
        bit   got;
        int   sx [4] = '{2047, -2048, 2047, -2048};
        int   sy [4] = '{2047, -2048, 2047, 1000};
        int   sz [4] = '{0, 0, 500, -600};
        bit   sm [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

        bus0.x_i = '0; bus0.y_i = '0; bus0.z_i = '0; bus0.mode_i = 1'b0;
        bus0.in_valid_i = 1'b0; bus0.out_ready_i = 1'b1;
        bus1.x_i = '0; bus1.y_i = '0; bus1.z_i = '0; bus1.mode_i = 1'b0;
        bus1.in_valid_i = 1'b0; bus1.out_ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_ready_during_reset", int'(bus0.in_ready_o), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", int'(bus0.out_valid_o), 0);
        chk("reset_x_o", int'(bus0.x_o), 0);
        chk("reset_y_o", int'(bus0.y_o), 0);
        chk("reset_z_o", int'(bus0.z_o), 0);
        chk("reset_in_ready", int'(bus0.in_ready_o), 1);

        // Rotation: latency and busy window
        send0(64, 0, 32, 1'b0);
        for (int k = 0; k <= IT0; k++) begin
            @(negedge clk);
            chk($sformatf("rot_out_valid_e%0d", k), int'(bus0.out_valid_o), (k == IT0) ? 1 : 0);
            chk($sformatf("rot_in_ready_e%0d", k), int'(bus0.in_ready_o), 0);
        end
        chk("rot_x_o", int'(bus0.x_o), 74);
        chk("rot_y_o", int'(bus0.y_o), 75);
        chk("rot_z_o", int'(bus0.z_o), -1);
        @(negedge clk);
        chk("rot_exit_out_valid", int'(bus0.out_valid_o), 0);
        chk("rot_exit_in_ready", int'(bus0.in_ready_o), 1);

        // Vectoring with x saturation
        send0(64, 64, 0, 1'b1);
        wait_out0();
        chk("vec_x_o", int'(bus0.x_o), 127);
        chk("vec_y_o", int'(bus0.y_o), -1);
        chk("vec_z_o", int'(bus0.z_o), 33);
        @(posedge clk); #1;

        // Backpressure with in_valid asserted throughout DONE
        bus0.out_ready_i = 1'b0;
        send0(40, -30, 20, 1'b0);
        e = model(N0, IT0, G0, 40, -30, 20, 1'b0);
        wait_out0();
        @(posedge clk); #1;
        bus0.x_i = 8'(10); bus0.y_i = 8'(-20); bus0.z_i = 8'(15); bus0.mode_i = 1'b1;
        bus0.in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(bus0.out_valid_o), 1);
            chk("bp_in_ready", int'(bus0.in_ready_o), 0);
            chk("bp_x_hold", int'(bus0.x_o), e.x);
            chk("bp_y_hold", int'(bus0.y_o), e.y);
            chk("bp_z_hold", int'(bus0.z_o), e.z);
        end
        @(posedge clk); #1 bus0.out_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", int'(bus0.out_valid_o), 0);
        chk("bp_release_in_ready", int'(bus0.in_ready_o), 1);
        @(posedge clk); #1 bus0.in_valid_i = 1'b0;
        wait_out0();
        @(posedge clk); #1;

        // Reset while counter == 3
        send0(50, 20, -10, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        q0.delete(); q1.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", int'(bus0.out_valid_o), 0);
        chk("abort_x_o", int'(bus0.x_o), 0);
        chk("abort_y_o", int'(bus0.y_o), 0);
        chk("abort_z_o", int'(bus0.z_o), 0);
        chk("abort_in_ready", int'(bus0.in_ready_o), 1);
        send0(-70, 33, 25, 1'b0);
        e = model(N0, IT0, G0, -70, 33, 25, 1'b0);
        wait_out0();
        chk("post_abort_x", int'(bus0.x_o), e.x);
        chk("post_abort_y", int'(bus0.y_o), e.y);
        chk("post_abort_z", int'(bus0.z_o), e.z);
        @(posedge clk); #1;

        // Back-to-back stream: accepts exactly ITERATIONS+2 cycles apart
        rand_in0();
        bus0.in_valid_i = 1'b1;
        for (int s = 0; s < 4; s++) begin
            got = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (bus0.in_ready_o) begin
                    acc[s] = cyc;
                    got = 1'b1;
                    break;
                end
            end
            if (!got) chk("stream_accept_timeout", 0, 1);
            @(posedge clk); #1;
            rand_in0();
        end
        bus0.in_valid_i = 1'b0;
        for (int s = 1; s < 4; s++) chk($sformatf("stream_spacing_%0d", s), acc[s] - acc[s-1], IT0 + 2);
        wait_out0();
        @(posedge clk); #1;

        // Random default-parameter vectors in both modes
        for (int v = 0; v < 30; v++) begin
            send0(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, 1'($urandom));
            wait_out0();
            @(posedge clk); #1;
        end

        // Wide engine: saturation corners then random vectors, random stalls
        for (int v = 0; v < 44; v++) begin
            if (v < 4)
                send1(sx[v], sy[v], sz[v], sm[v]);
            else
                send1(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                      int'($urandom_range(0, 4095)) - 2048, 1'($urandom));
            wait_out1();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1 bus1.out_ready_i = 1'b1;
            @(posedge clk); #1 bus1.out_ready_i = 1'b0;
        end

        repeat (5) @(posedge clk);
        chk("dut0_queue_drained", q0.size(), 0);
        chk("dut1_queue_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
